lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter ADDR_W, default 5, command-ROM address width (32 entries).
REQ-002 Parameter TMO, default 80, timeout limit in cycles for the WAIT_RDY and WAIT_DONE states.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle pulse that launches a sequence; honoured only in IDLE.
REQ-006 Port CMD_ROM_EN  output  1  command-ROM read enable.
REQ-007 Port CMD_ROM_A  output  ADDR_W  command-ROM address.
REQ-008 Port CMD_ROM_Q  input  4  ROM data, valid one cycle after EN; [2:0] is the opcode, [3] is the LAST flag.
REQ-009 Port lcd_busy  input  1  LCD controller busy; a command is accepted only while it is low.
REQ-010 Port lcd_done  input  1  LCD controller done; image write-back is complete.
REQ-011 Port cmd  output  3  opcode to the LCD controller: 0 write, 1 up, 2 down, 3 left, 4 right, 5 avg, 6 mirror-X, 7 mirror-Y.
REQ-012 Port cmd_valid  output  1  one-cycle command strobe.
REQ-013 Port seq_busy  output  1  a sequence is in progress.
REQ-014 Port seq_done  output  1  sticky; the sequence completed successfully.
REQ-015 Port seq_err  output  1  sticky; the sequence aborted on timeout or address overflow.
REQ-016 Port issued_cnt  output  6  count of commands issued in the current sequence, saturating at 63.

Function
REQ-017 FSM states: IDLE, WAIT_RDY, FETCH, LATCH, ISSUE, GAP, WAIT_DONE, DONE, ERR.
REQ-018 IDLE: on start=1, go to WAIT_RDY; clear seq_done, seq_err, issued_cnt and the address; set seq_busy=1.
REQ-019 WAIT_RDY: remain until lcd_busy=0, then go to FETCH; after TMO cycles with lcd_busy still high, go to ERR.
REQ-020 FETCH: drive CMD_ROM_EN=1 and CMD_ROM_A=address for exactly one cycle, then go to LATCH.
REQ-021 LATCH: capture CMD_ROM_Q into an opcode register and a last register, then go to ISSUE.
REQ-022 ISSUE: wait while lcd_busy=1; in the first cycle with lcd_busy=0, drive cmd=opcode and cmd_valid=1 for exactly one cycle and increment issued_cnt.
REQ-023 cmd_valid is never high in two consecutive cycles; at least one GAP cycle follows each strobe.
REQ-024 After issuing opcode 0, go to WAIT_DONE and ignore the last flag.
REQ-025 After issuing a non-zero opcode with last=1, go to GAP, then reload the opcode register with 0 internally (no ROM read) and return to ISSUE; this auto-appends the write-back command.
REQ-026 After issuing a non-zero opcode with last=0, go to GAP, increment the address, then go to FETCH.
REQ-027 Address overflow: if the incremented address would wrap past 2^ADDR_W-1 and the last flag was 0, go to ERR instead of FETCH.
REQ-028 WAIT_DONE: on lcd_done=1, go to DONE; after TMO cycles without lcd_done, go to ERR.
REQ-029 DONE: set seq_done=1 and seq_busy=0, then return to IDLE; seq_done holds until the next accepted start.
REQ-030 ERR: set seq_err=1 and seq_busy=0, then return to IDLE; never assert cmd_valid while in ERR.
REQ-031 start is ignored in every state other than IDLE.
REQ-032 The timeout counter clears on every state entry, is 7 bits wide, and saturates.
REQ-033 cmd holds its last value when cmd_valid=0; CMD_ROM_A holds its value when EN=0.

Reset
REQ-034 While reset=1, asynchronously force: state IDLE; cmd_valid=0; CMD_ROM_EN=0; CMD_ROM_A=0; cmd=0; issued_cnt=0; seq_busy=0; seq_done=0; seq_err=0; timeout counter 0.
REQ-035 Reset asserted mid-sequence aborts immediately with no further cmd_valid; the first cycle after release is IDLE.

Verification
REQ-036 ROM {4,2,5|LAST}, lcd_busy low, start -> cmd_valid pulses carrying 4, 2, 5, 0 with a gap of ≥1 cycle between pulses; then lcd_done -> seq_done=1, issued_cnt=4.
REQ-037 lcd_busy held high for 65 cycles after start -> no ROM read until it falls; the first cmd_valid follows within 3 cycles.
REQ-038 ROM {3,0,...} -> issued 3, 0; no further ROM read after the 0; seq_done after lcd_done; issued_cnt=2.
REQ-039 ROM with 32 entries and no LAST flag, opcode 1 -> 32 strobes, then seq_err=1, seq_done=0.
REQ-040 lcd_done never asserted -> seq_err=1 exactly TMO cycles after WAIT_DONE entry; start pulsed while busy -> ignored.
REQ-041 reset pulsed during the third ISSUE -> all outputs zero; a new start reruns from address 0.

Source files
------------

// File: rtl/lcd_cmd_seq.sv
// Command sequencer: walks a small opcode ROM and strobes each opcode into an LCD
// image controller, auto-appending the write-back (opcode 0) after the LAST entry.
module lcd_cmd_seq #(
    parameter int ADDR_W = 5,
    parameter int TMO    = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CMD_ROM_EN,
    output logic [ADDR_W-1:0] CMD_ROM_A,
    input  logic [3:0]        CMD_ROM_Q,
    input  logic              lcd_busy,
    input  logic              lcd_done,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [5:0]        issued_cnt
);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, FETCH, LATCH, ISSUE, GAP, WAIT_DONE, DONE, ERR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rom_a;
    logic [2:0]        opcode;
    logic [2:0]        cmd_hold;
    logic              last;
    logic [6:0]        tmo_cnt;
    logic              tmo_hit;

    assign tmo_hit    = (tmo_cnt >= 7'(TMO - 1));
    assign CMD_ROM_EN = (state == FETCH);
    assign CMD_ROM_A  = rom_a;
    assign cmd_valid  = (state == ISSUE) && !lcd_busy;
    // cmd follows the opcode only during the strobe, otherwise shows the last one sent
    assign cmd        = cmd_valid ? opcode : cmd_hold;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_RDY;
            WAIT_RDY: begin
                if (!lcd_busy)    state_nxt = FETCH;
                else if (tmo_hit) state_nxt = ERR;
            end
            FETCH:     state_nxt = LATCH;
            LATCH:     state_nxt = ISSUE;
            ISSUE:     if (!lcd_busy) state_nxt = (opcode == 3'd0) ? WAIT_DONE : GAP;
            GAP: begin
                if (last)                  state_nxt = ISSUE;
                else if (addr == ADDR_MAX) state_nxt = ERR;
                else                       state_nxt = FETCH;
            end
            WAIT_DONE: begin
                if (lcd_done)     state_nxt = DONE;
                else if (tmo_hit) state_nxt = ERR;
            end
            DONE:      state_nxt = IDLE;
            ERR:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            rom_a      <= '0;
            opcode     <= '0;
            cmd_hold   <= '0;
            last       <= 1'b0;
            tmo_cnt    <= '0;
            issued_cnt <= '0;
            seq_busy   <= 1'b0;
            seq_done   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state <= state_nxt;

            // restart the timeout window on every state change
            if (state_nxt != state)   tmo_cnt <= '0;
            else if (tmo_cnt != 7'h7f) tmo_cnt <= tmo_cnt + 7'd1;

            if (state == IDLE && start) begin
                addr       <= '0;
                issued_cnt <= '0;
                seq_done   <= 1'b0;
                seq_err    <= 1'b0;
                seq_busy   <= 1'b1;
            end

            // ROM address only moves on the edge into FETCH so it is stable otherwise
            if (state == WAIT_RDY && state_nxt == FETCH)
                rom_a <= addr;
            if (state == GAP && state_nxt == FETCH) begin
                addr  <= addr + 1'b1;
                rom_a <= addr + 1'b1;
            end

            if (state == LATCH) begin
                opcode <= CMD_ROM_Q[2:0];
                last   <= CMD_ROM_Q[3];
            end
            if (state == GAP && last)
                opcode <= 3'd0;

            if (cmd_valid) begin
                cmd_hold <= opcode;
                if (issued_cnt != 6'h3f) issued_cnt <= issued_cnt + 6'd1;
            end

            if (state_nxt == DONE) begin
                seq_done <= 1'b1;
                seq_busy <= 1'b0;
            end
            if (state_nxt == ERR) begin
                seq_err  <= 1'b1;
                seq_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: stimulus pushes expected opcodes into a queue,
// a negedge monitor pops and compares every cmd_valid strobe.
module tb_lcd_cmd_seq;
    localparam int ADDR_W = 5;
    localparam int TMO    = 80;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              CMD_ROM_EN;
    logic [ADDR_W-1:0] CMD_ROM_A;
    logic [3:0]        CMD_ROM_Q;
    logic              lcd_busy = 1'b0;
    logic              lcd_done = 1'b0;
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic              seq_busy, seq_done, seq_err;
    logic [5:0]        issued_cnt;

    lcd_cmd_seq #(.ADDR_W(ADDR_W), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .CMD_ROM_EN(CMD_ROM_EN), .CMD_ROM_A(CMD_ROM_A), .CMD_ROM_Q(CMD_ROM_Q),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .cmd(cmd), .cmd_valid(cmd_valid),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    logic [3:0] rom [32];
    int         reads = 0;
    int         errors = 0;
    int         checks = 0;
    int         exp_q[$];

    // synchronous ROM model, one cycle read latency
    always @(posedge clk) begin
        if (CMD_ROM_EN) begin
            CMD_ROM_Q <= rom[CMD_ROM_A];
            reads     <= reads + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // monitor: scoreboard compare, gap rule and cmd hold
    logic [2:0] last_cmd = 3'd0;
    logic       prev_v   = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            last_cmd = 3'd0;
            prev_v   = 1'b0;
        end else begin
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", int'(cmd), -1);
                end else begin
                    chk("cmd", int'(cmd), exp_q.pop_front());
                end
                chk("gap", int'(prev_v), 0);
                last_cmd = cmd;
            end else begin
                chk("cmd_hold", int'(cmd), int'(last_cmd));
            end
            prev_v = cmd_valid;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic finish_done(input string name, input int exp_cnt);
        int n = 0;
        lcd_done = 1'b1;
        while (!seq_done && n < 50) begin tick(); n++; end
        lcd_done = 1'b0;
        chk({name, "_done"}, int'(seq_done), 1);
        chk({name, "_err"}, int'(seq_err), 0);
        tick();
        chk({name, "_busy"}, int'(seq_busy), 0);
        chk({name, "_cnt"}, int'(issued_cnt), exp_cnt);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 32; i++) rom[i] = 4'h0;
    endtask

    initial begin
        int n;
        int r0;
        clear_rom();
        repeat (3) tick();
        // outputs under reset
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_en", int'(CMD_ROM_EN), 0);
        chk("rst_addr", int'(CMD_ROM_A), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_cnt", int'(issued_cnt), 0);
        chk("rst_flags", int'({seq_busy, seq_done, seq_err}), 0);
        reset = 1'b0;
        repeat (2) tick();

        // basic sequence with auto-appended write-back
        clear_rom();
        rom[0] = 4'h4; rom[1] = 4'h2; rom[2] = 4'hD;
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(0);
        pulse_start();
        chk("t1_busy", int'(seq_busy), 1);
        wait_drain("t1_drain");
        finish_done("t1", 4);

        // controller busy for 65 cycles after start
        clear_rom();
        rom[0] = 4'h9;
        exp_q.push_back(1); exp_q.push_back(0);
        r0 = reads;
        lcd_busy = 1'b1;
        pulse_start();
        repeat (64) tick();
        chk("t2_no_read", reads - r0, 0);
        chk("t2_no_err", int'(seq_err), 0);
        lcd_busy = 1'b0;
        n = 0;
        while (!cmd_valid && n < 10) begin tick(); n++; end
        chk("t2_latency", int'(cmd_valid && n <= 3), 1);
        wait_drain("t2_drain");
        finish_done("t2", 2);

        // explicit opcode 0 ends the list
        clear_rom();
        rom[0] = 4'h3; rom[1] = 4'h0; rom[2] = 4'h7;
        exp_q.push_back(3); exp_q.push_back(0);
        r0 = reads;
        pulse_start();
        wait_drain("t3_drain");
        repeat (5) tick();
        finish_done("t3", 2);
        chk("t3_reads", reads - r0, 2);

        // 32 entries without LAST: address overflow
        for (int i = 0; i < 32; i++) begin rom[i] = 4'h1; exp_q.push_back(1); end
        pulse_start();
        n = 0;
        while (!seq_err && n < 400) begin tick(); n++; end
        chk("t4_err", int'(seq_err), 1);
        chk("t4_done", int'(seq_done), 0);
        chk("t4_cnt", int'(issued_cnt), 32);
        chk("t4_left", exp_q.size(), 0);
        tick();
        chk("t4_busy", int'(seq_busy), 0);

        // lcd_done never comes: timeout, start while busy ignored
        clear_rom();
        rom[0] = 4'hE;
        exp_q.push_back(6); exp_q.push_back(0);
        pulse_start();
        wait_drain("t5_drain");
        r0 = reads;
        n = 0;
        while (!seq_err && n < 200) begin
            start = (n == 10);
            tick();
            n++;
        end
        start = 1'b0;
        chk("t5_tmo", n, TMO);
        chk("t5_done", int'(seq_done), 0);
        repeat (3) tick();
        chk("t5_idle", int'(seq_busy), 0);
        chk("t5_reads", reads - r0, 0);

        // reset during the third ISSUE, then rerun
        clear_rom();
        rom[0] = 4'h2; rom[1] = 4'h3; rom[2] = 4'h4; rom[3] = 4'hD;
        exp_q.push_back(2); exp_q.push_back(3);
        pulse_start();
        n = 0;
        while (!(CMD_ROM_EN && CMD_ROM_A == 5'd2) && n < 200) begin tick(); n++; end
        chk("t6_fetch2", int'(CMD_ROM_EN), 1);
        lcd_busy = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("t6_valid", int'(cmd_valid), 0);
        chk("t6_en", int'(CMD_ROM_EN), 0);
        chk("t6_addr", int'(CMD_ROM_A), 0);
        chk("t6_cmd", int'(cmd), 0);
        chk("t6_cnt", int'(issued_cnt), 0);
        chk("t6_flags", int'({seq_busy, seq_done, seq_err}), 0);
        chk("t6_left", exp_q.size(), 0);
        exp_q.delete();
        lcd_busy = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("t6_idle", int'({seq_busy, CMD_ROM_EN}), 0);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
        exp_q.push_back(5); exp_q.push_back(0);
        pulse_start();
        n = 0;
        while (!CMD_ROM_EN && n < 20) begin tick(); n++; end
        chk("t6_rerun_addr", int'(CMD_ROM_A), 0);
        wait_drain("t6_drain");
        finish_done("t6", 5);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
